// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-fetch front end.
// Holds the redirect-select encodings, fetch exception codes, the address
// map constants of the instruction ROM, and a helper that classifies a
// fetch address as illegal.
package cpu_defs;

    // Redirect select as resolved in the decode stage
    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT   = 32'h0000_4FFC;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP        = 32'h0000_0000;

    // A fetch is illegal when misaligned or outside the ROM window
    function automatic logic fetch_addr_bad(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
    endfunction

endpackage

// File: rtl/npc_mux.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc_f       current fetch address
//   stall      decode hazard stall (hold PC)
//   npc_sel    redirect select (seq / branch / j / jr)
//   br_target, j_target, jr_target   redirect targets
//   exc_entry  exception entry this cycle (highest priority)
//   eret       eret committing this cycle
//   epc        return address for eret
//   npc        next fetch address
//   fetch_err  current fetch address is misaligned or outside the ROM
module npc_mux
    import cpu_defs::*;
(
    input  logic [31:0] pc_f,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    input  logic        exc_entry,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        fetch_err
);

    npc_sel_e    sel_s;
    logic [31:0] seq_pc_s;

    assign sel_s    = npc_sel_e'(npc_sel);
    // Sequential successor wraps naturally at 32 bits
    assign seq_pc_s = pc_f + 32'd4;

    // Next-PC priority: exception entry, eret, stall, then redirect select
    always_comb begin
        npc = seq_pc_s;
        if (exc_entry) begin
            npc = EXC_VECTOR;
        end else if (eret) begin
            npc = epc;
        end else if (stall) begin
            npc = pc_f;
        end else begin
            case (sel_s)
                NPC_BR:  npc = br_target;
                NPC_J:   npc = j_target;
                NPC_JR:  npc = jr_target;
                NPC_SEQ: npc = seq_pc_s;
                default: npc = seq_pc_s;
            endcase
        end
    end

    // Address error is evaluated on the address actually being fetched
    always_comb begin
        fetch_err = fetch_addr_bad(pc_f);
    end

endmodule

// File: rtl/if_stage_pc.sv
// Instruction-fetch stage front end of the 5-stage MIPS pipeline.
// Owns the fetch PC register, the IF/ID pipeline register and the count of
// valid instructions handed to decode.
// Ports:
//   clk, reset (sync, active-low)
//   stall, npc_sel, br_target, j_target, jr_target   redirect/stall controls
//   is_jump_D  instruction in D is a branch/jump (next capture is a delay slot)
//   exc_entry, eret, epc   CP0 control flow
//   instr_in   ROM word for PC_F
//   PC_F       fetch address to the ROM
//   IR_D, PC_D, PC8_D, exc_D, bd_D   IF/ID register contents
//   fetch_cnt  valid instructions delivered to D
module if_stage_pc
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    input  logic        is_jump_D,
    input  logic        exc_entry,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic [31:0] instr_in,
    output logic [31:0] PC_F,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic [4:0]  exc_D,
    output logic        bd_D,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc_f_r;
    logic [31:0] ir_d_r;
    logic [31:0] pc_d_r;
    logic [31:0] pc8_d_r;
    logic [4:0]  exc_d_r;
    logic        bd_d_r;
    logic [31:0] fetch_cnt_r;

    logic [31:0] npc_s;
    logic        fetch_err_s;
    logic [31:0] pc8_s;

    npc_mux u_npc_mux (
        .pc_f      (pc_f_r),
        .stall     (stall),
        .npc_sel   (npc_sel),
        .br_target (br_target),
        .j_target  (j_target),
        .jr_target (jr_target),
        .exc_entry (exc_entry),
        .eret      (eret),
        .epc       (epc),
        .npc       (npc_s),
        .fetch_err (fetch_err_s)
    );

    assign pc8_s = pc_f_r + 32'd8;

    // Fetch PC register; the mux already folds stall/redirect priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f_r <= PC_RESET;
        end else begin
            pc_f_r <= npc_s;
        end
    end

    // IF/ID register and delivered-instruction counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_d_r      <= NOP;
            pc_d_r      <= 32'h0000_0000;
            pc8_d_r     <= 32'h0000_0000;
            exc_d_r     <= EXC_NONE;
            bd_d_r      <= 1'b0;
            fetch_cnt_r <= 32'h0000_0000;
        end else if (exc_entry || eret) begin
            // Bubble, but PC_D still carries a usable address for CP0
            ir_d_r      <= NOP;
            pc_d_r      <= pc_f_r;
            pc8_d_r     <= pc8_s;
            exc_d_r     <= EXC_NONE;
            bd_d_r      <= 1'b0;
            fetch_cnt_r <= fetch_cnt_r;
        end else if (stall) begin
            ir_d_r      <= ir_d_r;
            pc_d_r      <= pc_d_r;
            pc8_d_r     <= pc8_d_r;
            exc_d_r     <= exc_d_r;
            bd_d_r      <= bd_d_r;
            fetch_cnt_r <= fetch_cnt_r;
        end else if (fetch_err_s) begin
            // Bad fetch travels to D as a nop tagged AdEL; not counted
            ir_d_r      <= NOP;
            pc_d_r      <= pc_f_r;
            pc8_d_r     <= pc8_s;
            exc_d_r     <= EXC_ADEL;
            bd_d_r      <= is_jump_D;
            fetch_cnt_r <= fetch_cnt_r;
        end else begin
            ir_d_r      <= instr_in;
            pc_d_r      <= pc_f_r;
            pc8_d_r     <= pc8_s;
            exc_d_r     <= EXC_NONE;
            bd_d_r      <= is_jump_D;
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
        end
    end

    assign PC_F      = pc_f_r;
    assign IR_D      = ir_d_r;
    assign PC_D      = pc_d_r;
    assign PC8_D     = pc8_d_r;
    assign exc_D     = exc_d_r;
    assign bd_D      = bd_d_r;
    assign fetch_cnt = fetch_cnt_r;

endmodule

// File: tb/tb_if_stage_pc.sv
// Self-checking bench for if_stage_pc: a cycle model of the fetch stage is
// compared against every output on each falling edge, and directed literal
// expectations pin the model at key points of the sequence.
module tb_if_stage_pc;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic [31:0] br_target, j_target, jr_target, epc;
    logic        is_jump_D, exc_entry, eret;
    logic [31:0] instr_in;
    logic [31:0] PC_F, IR_D, PC_D, PC8_D, fetch_cnt;
    logic [4:0]  exc_D;
    logic        bd_D;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // ROM contents: distinct word per address so captures are traceable
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {16'h2408, a[15:0]};
    endfunction

    assign instr_in = rom(PC_F);

    if_stage_pc dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
        .br_target(br_target), .j_target(j_target), .jr_target(jr_target),
        .is_jump_D(is_jump_D), .exc_entry(exc_entry), .eret(eret), .epc(epc),
        .instr_in(instr_in), .PC_F(PC_F), .IR_D(IR_D), .PC_D(PC_D),
        .PC8_D(PC8_D), .exc_D(exc_D), .bd_D(bd_D), .fetch_cnt(fetch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_ir, m_pcd, m_pc8, m_cnt;
    logic [4:0]  m_exc;
    logic        m_bd;
    logic        m_valid = 1'b0;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (a < 32'h3000) || (a > 32'h4FFC);
    endfunction

    function automatic logic [31:0] target_of(input logic [1:0] s, input logic [31:0] pc);
        logic [31:0] t;
        t = (s == 2'd1) ? br_target :
            (s == 2'd2) ? j_target  :
            (s == 2'd3) ? jr_target : pc + 32'd4;
        return t;
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            m_valid <= 1'b1;
            m_pc <= 32'h3000; m_ir <= 32'h0; m_pcd <= 32'h0; m_pc8 <= 32'h0;
            m_exc <= 5'd0; m_bd <= 1'b0; m_cnt <= 32'h0;
        end else if (m_valid) begin
            if (exc_entry || eret) begin
                m_pc  <= exc_entry ? 32'h4180 : epc;
                m_ir  <= 32'h0; m_exc <= 5'd0; m_bd <= 1'b0;
                m_pcd <= m_pc;  m_pc8 <= m_pc + 32'd8;
            end else if (!stall) begin
                m_pc  <= target_of(npc_sel, m_pc);
                m_pcd <= m_pc;  m_pc8 <= m_pc + 32'd8;
                m_bd  <= is_jump_D;
                m_ir  <= bad_addr(m_pc) ? 32'h0 : rom(m_pc);
                m_exc <= bad_addr(m_pc) ? 5'd4 : 5'd0;
                m_cnt <= bad_addr(m_pc) ? m_cnt : m_cnt + 32'd1;
            end
        end
    end

    // Compare every output against the model once outputs are defined
    always @(negedge clk) begin
        if (m_valid) begin
            chk("PC_F",      PC_F,      m_pc);
            chk("IR_D",      IR_D,      m_ir);
            chk("PC_D",      PC_D,      m_pcd);
            chk("PC8_D",     PC8_D,     m_pc8);
            chk("exc_D",     {27'd0, exc_D}, {27'd0, m_exc});
            chk("bd_D",      {31'd0, bd_D},  {31'd0, m_bd});
            chk("fetch_cnt", fetch_cnt, m_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; npc_sel = 2'd0; is_jump_D = 1'b0;
        exc_entry = 1'b0; eret = 1'b0;
        br_target = 32'h0; j_target = 32'h0; jr_target = 32'h0; epc = 32'h0;

        tick(); tick();
        chk("rst_pc", PC_F, 32'h3000);
        chk("rst_ir", IR_D, 32'h0);
        chk("rst_cnt", fetch_cnt, 32'h0);

        reset = 1'b1;
        tick();
        chk("seq1_pc",  PC_F,  32'h3004);
        chk("seq1_ir",  IR_D,  32'h2408_3000);
        chk("seq1_pcd", PC_D,  32'h3000);
        chk("seq1_pc8", PC8_D, 32'h3008);
        chk("seq1_cnt", fetch_cnt, 32'd1);
        tick();
        chk("seq2_pc",  PC_F,  32'h3008);
        chk("seq2_cnt", fetch_cnt, 32'd2);
        tick(); tick();
        chk("seq4_pc",  PC_F,  32'h3010);

        // branch taken at 0x3010, target fetched next with bd marked
        npc_sel = 2'd1; br_target = 32'h3040;
        tick();
        chk("br_pc", PC_F, 32'h3040);
        npc_sel = 2'd0; is_jump_D = 1'b1;
        tick();
        chk("br_pcd", PC_D, 32'h3040);
        chk("br_bd",  {31'd0, bd_D}, 32'd1);
        chk("br_cnt", fetch_cnt, 32'd6);
        is_jump_D = 1'b0;

        // stall three cycles at 0x3020
        npc_sel = 2'd2; j_target = 32'h3020;
        tick();
        npc_sel = 2'd0; stall = 1'b1;
        tick(); tick(); tick();
        chk("stall_pc",  PC_F, 32'h3020);
        chk("stall_pcd", PC_D, 32'h3044);
        chk("stall_cnt", fetch_cnt, 32'd7);
        stall = 1'b0;
        tick();
        chk("unstall_pc", PC_F, 32'h3024);

        // exception entry overrides stall at 0x3050
        npc_sel = 2'd3; jr_target = 32'h3050;
        tick();
        npc_sel = 2'd0; stall = 1'b1; exc_entry = 1'b1;
        tick();
        chk("exc_pc",  PC_F, 32'h4180);
        chk("exc_ir",  IR_D, 32'h0);
        chk("exc_pcd", PC_D, 32'h3050);
        stall = 1'b0;
        // exc_entry beats eret when both fire
        eret = 1'b1; epc = 32'h3054;
        tick();
        chk("exc_eret_pc", PC_F, 32'h4180);
        exc_entry = 1'b0;
        tick();
        chk("eret_pc", PC_F, 32'h3054);
        eret = 1'b0;
        tick();

        // misaligned jr target: fetched, then AdEL in D
        npc_sel = 2'd3; jr_target = 32'h3002;
        tick();
        chk("mis_pc", PC_F, 32'h3002);
        npc_sel = 2'd0;
        tick();
        chk("mis_exc", {27'd0, exc_D}, 32'd4);
        chk("mis_pcd", PC_D, 32'h3002);
        chk("mis_cnt", fetch_cnt, 32'd11);

        // out-of-range target, then top legal word
        npc_sel = 2'd3; jr_target = 32'h5000;
        tick();
        npc_sel = 2'd0;
        tick();
        chk("oor_exc", {27'd0, exc_D}, 32'd4);
        chk("oor_pcd", PC_D, 32'h5000);
        npc_sel = 2'd3; jr_target = 32'h4FFC;
        tick();
        npc_sel = 2'd0;
        tick();
        chk("lim_exc", {27'd0, exc_D}, 32'd0);
        chk("lim_ir",  IR_D, 32'h2408_4FFC);
        chk("lim_cnt", fetch_cnt, 32'd12);

        // below base and wrap-around of PC+4
        npc_sel = 2'd3; jr_target = 32'hFFFF_FFFC;
        tick();
        npc_sel = 2'd0;
        tick();
        chk("wrap_pc",  PC_F, 32'h0);
        chk("wrap_exc", {27'd0, exc_D}, 32'd4);

        // reset during a stall at 0x4000 with a pending redirect
        npc_sel = 2'd3; jr_target = 32'h4000;
        tick();
        npc_sel = 2'd1; br_target = 32'h3333_3330; stall = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("mrst_pc",  PC_F, 32'h3000);
        chk("mrst_pcd", PC_D, 32'h0);
        chk("mrst_cnt", fetch_cnt, 32'h0);
        reset = 1'b1; stall = 1'b0; npc_sel = 2'd0;
        tick();
        chk("post_pc",  PC_F, 32'h3004);
        chk("post_cnt", fetch_cnt, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage_pc.md
Name: if_stage_pc

Overview:
- Instruction-fetch stage front end of the 5-stage MIPS pipeline.
- Holds the fetch PC that drives the instruction ROM and selects the next PC: sequential, branch, jump, jr, exception entry, or eret.
- Detects fetch address errors.
- Owns the IF/ID pipeline register that the decode stage consumes.

Parameters:
- PC_RESET, 32'h0000_3000, first fetch address after reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_4FFC, highest legal fetch address (2048-word ROM).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- stall  in  1  hazard stall from decode; hold PC_F and the IF/ID register.
- npc_sel  in  2  redirect select resolved in D: 0 = seq, 1 = branch, 2 = j/jal, 3 = jr/jalr.
- br_target  in  32  branch target address.
- j_target  in  32  j/jal target address.
- jr_target  in  32  register target address.
- is_jump_D  in  1  the instruction currently in D is a branch or jump (marks the next fetch as a delay slot).
- exc_entry  in  1  exception or interrupt taken this cycle (from CP0).
- eret  in  1  eret committing this cycle.
- epc  in  32  return address for eret.
- instr_in  in  32  word returned by the instruction ROM for PC_F (combinational).
- PC_F  out  32  current fetch address, sent to the instruction ROM.
- IR_D  out  32  instruction latched for decode.
- PC_D  out  32  address of IR_D.
- PC8_D  out  32  PC_D+8 (link value).
- exc_D  out  5  fetch exception code for IR_D: 0 = none, 4 = AdEL.
- bd_D  out  1  IR_D is in a branch delay slot.
- fetch_cnt  out  32  count of valid instructions delivered to D.

Behaviour:
- Reset (reset==0 at the edge): PC_F=PC_RESET; IR_D=0; PC_D=0; PC8_D=0; exc_D=0; bd_D=0; fetch_cnt=0. Reset wins over every other input.
- Next PC priority, highest first:
  1. exc_entry: EXC_VECTOR.
  2. eret: epc.
  3. stall: hold PC_F.
  4. npc_sel 1/2/3: br_target, j_target, jr_target respectively.
  5. Otherwise: PC_F+4, 32-bit with wrap-around and no carry out.
- exc_entry and eret override stall.
- Redirects are registered, so the instruction at old PC_F+4 (the delay slot) is fetched normally. There is no squash on branch.
- Fetch error: fetch_err = (PC_F[1:0]!=0) | (PC_F<IM_BASE) | (PC_F>IM_LIMIT), unsigned compare, combinational.
- IF/ID register update, priority order:
  - exc_entry, eret: load a bubble. IR_D=0 (sll nop), exc_D=0, bd_D=0, PC_D=PC_F, PC8_D=PC_F+8. PC_D keeps a meaningful address for CP0. fetch_cnt unchanged.
  - stall (neither of the above): hold all IF/ID fields and fetch_cnt.
  - Otherwise:
    - PC_D=PC_F, PC8_D=PC_F+8, bd_D=is_jump_D.
    - If fetch_err: IR_D=0, exc_D=4, fetch_cnt unchanged.
    - Else: IR_D=instr_in, exc_D=0, fetch_cnt+1 (wraps at 2^32).
- Latency: instr_in for PC_F appears on IR_D one cycle later. A redirect presented in cycle t makes PC_F equal the target in cycle t+1.
- Simultaneous exc_entry and eret: exc_entry wins for both PC and IF/ID.
- A misaligned target does not trap at redirect time. It is fetched and flagged AdEL when it reaches D.
- Reset mid-operation: any pending redirect or stall is discarded. The first fetch after reset release is PC_RESET.

Decomposition:
- Shared package (cpu_defs):
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings.
  - EXC_NONE=0, EXC_ADEL=4.
  - PC_RESET, EXC_VECTOR, IM_BASE, IM_LIMIT.
  - NOP = 32'h0.
- One sub-module, npc_mux: purely combinational next-PC priority select plus fetch_err. The top level holds the PC register, the IF/ID register and fetch_cnt.

Test Plan:
- Reset low 2 cycles, then release, no stall, instr_in = 0x24080001: PC_F steps 0x3000, 0x3004, 0x3008. IR_D = 0x24080001 with PC_D = 0x3000 and PC8_D = 0x3008 one cycle after PC_F = 0x3000. fetch_cnt increments by 1 per cycle.
- At PC_F = 0x3010 apply npc_sel = 1, br_target = 0x3040 for one cycle, with is_jump_D = 1 the following cycle: PC_F goes 0x3010 → 0x3040. The instruction at 0x3014 does not exist; the D entry for 0x3040 has bd_D = 1 only if is_jump_D was high at its capture.
- stall held 3 cycles at PC_F = 0x3020: PC_F, IR_D, PC_D and fetch_cnt are frozen. After release, PC_F advances to 0x3024.
- stall = 1 and exc_entry = 1 in the same cycle at PC_F = 0x3050: next PC_F = 0x4180, IR_D = 0, exc_D = 0, PC_D = 0x3050. Then eret with epc = 0x3054: PC_F = 0x3054 next cycle.
- npc_sel = 3, jr_target = 0x3002: PC_F = 0x3002, then IR_D = 0, exc_D = 4, PC_D = 0x3002, fetch_cnt unchanged. Repeat with jr_target = 0x5000: same AdEL response.
- Assert reset = 0 during a stall at PC_F = 0x4000: next edge gives PC_F = 0x3000 and all IF/ID fields and fetch_cnt = 0.
